// File: rtl/arb_pkg.sv
// Shared types and constants for the IF/MEM external-memory arbiter.
package arb_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      DATA     = 3'd2,
      IF_DONE  = 3'd3,
      MEM_DONE = 3'd4
   } arb_state_t;

   typedef enum logic {
      GRANT_IF  = 1'b0,
      GRANT_MEM = 1'b1
   } grant_t;

   // ARM "mov r0, r0": a harmless instruction to hand IF when a fetch is aborted.
   localparam logic [31:0] NOP_INST_DEFAULT = 32'hE1A00000;

   function automatic logic is_busy(input arb_state_t s);
      return (s == FETCH) || (s == DATA);
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts busy cycles without an external ack and flags the cycle on which the
// transaction must be abandoned.
module bus_watchdog
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic busy,
   input  logic ack,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q;

   // An ack in the final allowed cycle still counts as a good completion.
   assign expire = busy && !ack && (count_q == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (busy && !ack && (count_q != '1)) begin
         count_q <= count_q + CW'(1);
      end
   end

endmodule

// File: rtl/if_mem_arbiter.sv
// Shares one single-port external memory between instruction fetch and data
// access, alternating on conflict and aborting transactions that never ack.
module if_mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_inst,
   output logic              if_freeze,
   input  logic              mem_rd_en,
   input  logic              mem_wr_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              ext_req,
   output logic              ext_we,
   output logic [ADDR_W-1:0] ext_addr,
   output logic [DATA_W-1:0] ext_wdata,
   input  logic [DATA_W-1:0] ext_rdata,
   input  logic              ext_ack,
   output logic              bus_err
);

   arb_state_t state;
   grant_t     last_grant;

   logic data_pend;
   logic grant_mem;
   logic busy;
   logic expire;

   assign data_pend = mem_rd_en | mem_wr_en;
   // Data wins when alone, or on conflict when IF had the previous grant.
   assign grant_mem = data_pend && (!if_req || (last_grant == GRANT_IF));
   assign busy      = is_busy(state);

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (!busy),
      .busy   (busy),
      .ack    (ext_ack),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= GRANT_IF;
         ext_req    <= 1'b0;
         ext_we     <= 1'b0;
         ext_addr   <= '0;
         ext_wdata  <= '0;
         if_inst    <= '0;
         mem_rdata  <= '0;
         if_freeze  <= 1'b1;
         mem_ready  <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_mem) begin
                  state      <= DATA;
                  last_grant <= GRANT_MEM;
                  ext_req    <= 1'b1;
                  ext_we     <= mem_wr_en;
                  ext_addr   <= mem_addr;
                  ext_wdata  <= mem_wdata;
               end else if (if_req) begin
                  state      <= FETCH;
                  last_grant <= GRANT_IF;
                  ext_req    <= 1'b1;
                  ext_we     <= 1'b0;
                  ext_addr   <= if_addr;
                  ext_wdata  <= '0;
               end
            end
            FETCH: begin
               if (ext_ack || expire) begin
                  state     <= IF_DONE;
                  ext_req   <= 1'b0;
                  if_freeze <= 1'b0;
                  if (ext_ack) begin
                     if_inst <= ext_rdata;
                  end else begin
                     if_inst <= NOP_INST;
                     bus_err <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (ext_ack || expire) begin
                  state     <= MEM_DONE;
                  ext_req   <= 1'b0;
                  mem_ready <= 1'b1;
                  if (!ext_ack) begin
                     mem_rdata <= '0;
                     bus_err   <= 1'b1;
                  end else if (!ext_we) begin
                     mem_rdata <= ext_rdata;
                  end
               end
            end
            IF_DONE: begin
               state     <= IDLE;
               if_freeze <= 1'b1;
            end
            MEM_DONE: begin
               state     <= IDLE;
               mem_ready <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_mem_arbiter.sv
// Directed bench for if_mem_arbiter with a transaction-level reference model.
module tb_if_mem_arbiter;

   localparam int unsigned TO  = 4;
   localparam logic [31:0] NOP = 32'hE1A00000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req, mem_rd_en, mem_wr_en;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] if_inst, mem_rdata, ext_addr, ext_wdata, ext_rdata;
   logic        if_freeze, mem_ready, ext_req, ext_we, ext_ack, bus_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   if_mem_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .TIMEOUT  (TO),
      .NOP_INST (NOP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_inst   (if_inst),
      .if_freeze (if_freeze),
      .mem_rd_en (mem_rd_en),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .ext_req   (ext_req),
      .ext_we    (ext_we),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_rdata (ext_rdata),
      .ext_ack   (ext_ack),
      .bus_err   (bus_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'hE3A01005;
         32'h104: return 32'hA0B0C0D0;
         32'h200: return 32'h12345678;
         default: return a ^ 32'h5A5A5A5A;
      endcase
   endfunction

   // Memory responder: acks on busy cycle ack_delay (0 = never), plus stray acks on request.
   int ack_delay  = 1;
   int busy_n     = 0;
   int stray_req  = 0;
   int stray_done = 0;

   initial begin
      ext_ack   = 1'b0;
      ext_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         busy_n = ext_req ? busy_n + 1 : 0;
         if (stray_req != stray_done) begin
            stray_done++;
            ext_ack   = 1'b1;
            ext_rdata = 32'hFEEDF00D;
         end else if (ext_req && ack_delay != 0 && busy_n == ack_delay) begin
            ext_ack   = 1'b1;
            ext_rdata = mem_word(ext_addr);
         end else begin
            ext_ack   = 1'b0;
            ext_rdata = 32'hBAD0BAD0;
         end
      end
   end

   // Reference model: one in-flight transaction, a completion pulse, a turn bit for conflicts.
   int          m_cur;   // 0 none, 1 fetch, 2 data
   int          m_done;  // side completing this cycle
   int          m_age;
   bit          m_mem_turn, m_we, m_err;
   logic [31:0] m_addr, m_wdata, m_inst, m_rdata;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cur <= 0; m_done <= 0; m_age <= 0; m_mem_turn <= 1'b1; m_err <= 1'b0;
         m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_inst <= '0; m_rdata <= '0;
      end else if (m_done != 0) begin
         m_done <= 0;
      end else if (m_cur != 0) begin
         m_age <= m_age + 1;
         if (ext_ack || (m_age + 1 == TO)) begin
            m_done <= m_cur;
            m_cur  <= 0;
            if (!ext_ack) m_err <= 1'b1;
            if (m_cur == 1) m_inst <= ext_ack ? ext_rdata : NOP;
            else if (!ext_ack) m_rdata <= '0;
            else if (!m_we) m_rdata <= ext_rdata;
         end
      end else if ((mem_rd_en || mem_wr_en) && (!if_req || m_mem_turn)) begin
         m_cur <= 2; m_age <= 0; m_mem_turn <= 1'b0;
         m_addr <= mem_addr; m_we <= mem_wr_en; m_wdata <= mem_wdata;
      end else if (if_req) begin
         m_cur <= 1; m_age <= 0; m_mem_turn <= 1'b1;
         m_addr <= if_addr; m_we <= 1'b0; m_wdata <= '0;
      end
   end

   // Per-cycle comparison against the model, plus a log of grant order.
   int   glog[$];
   logic prev_req = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         check("ext_req", ext_req, m_cur != 0);
         check("if_freeze", if_freeze, m_done != 1);
         check("mem_ready", mem_ready, m_done == 2);
         check("bus_err", bus_err, m_err);
         if (m_cur != 0) begin
            check("ext_addr", ext_addr, m_addr);
            check("ext_we", ext_we, m_we);
            check("ext_wdata", ext_wdata, m_wdata);
         end
         if (m_done == 1) check("if_inst", if_inst, m_inst);
         if (m_done == 2) check("mem_rdata", mem_rdata, m_rdata);
         if (ext_req && !prev_req) glog.push_back(ext_addr == 32'h500 ? 2 : 1);
         prev_req = ext_req;
      end
   end

   // what: 0 = ext_req high, 1 = if_freeze low, 2 = mem_ready high
   task automatic wait_for(input string name, input int what, output int cycles, output int reqs);
      bit hit = 1'b0;
      cycles = 0;
      reqs   = 0;
      while (!hit && cycles < 50) begin
         @(negedge clk);
         cycles++;
         if (ext_req) reqs++;
         case (what)
            0:       hit = ext_req;
            1:       hit = !if_freeze;
            default: hit = mem_ready;
         endcase
      end
      if (!hit) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no event after %0d cycles", name, cycles);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #3; rst = 1'b0;
      @(posedge clk); #2; rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running at %0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      int c, nreq, base;
      if_req = 1'b0; if_addr = '0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
      mem_addr = '0; mem_wdata = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_ext_req", ext_req, 0);
      check("rst_ext_we", ext_we, 0);
      check("rst_ext_addr", ext_addr, 0);
      check("rst_ext_wdata", ext_wdata, 0);
      check("rst_if_inst", if_inst, 0);
      check("rst_mem_rdata", mem_rdata, 0);
      check("rst_if_freeze", if_freeze, 1);
      check("rst_mem_ready", mem_ready, 0);
      check("rst_bus_err", bus_err, 0);
      @(posedge clk); #2; rst = 1'b1;

      // Fetch alone, ack on second busy cycle
      ack_delay = 2;
      @(posedge clk); #2; if_req = 1'b1; if_addr = 32'h100;
      wait_for("fetch_done", 1, c, nreq);
      check("fetch_req_cycles", nreq, 2);
      check("fetch_latency", c, 4);
      check("fetch_inst", if_inst, 32'hE3A01005);
      @(posedge clk); #2; if_req = 1'b0;
      @(negedge clk);
      check("fetch_freeze_one_cycle", if_freeze, 1);

      // Conflict right after reset: data first, fetch straight after
      do_reset();
      ack_delay = 1;
      @(posedge clk); #2;
      if_req = 1'b1; if_addr = 32'h104; mem_rd_en = 1'b1; mem_addr = 32'h200;
      wait_for("conflict_grant", 0, c, nreq);
      check("conflict_first_addr", ext_addr, 32'h200);
      check("conflict_first_we", ext_we, 0);
      wait_for("conflict_data_done", 2, c, nreq);
      check("conflict_rdata", mem_rdata, 32'h12345678);
      @(posedge clk); #2; mem_rd_en = 1'b0;
      wait_for("conflict_fetch_grant", 0, c, nreq);
      check("conflict_gap", c, 2);
      check("conflict_second_addr", ext_addr, 32'h104);
      wait_for("conflict_fetch_done", 1, c, nreq);
      check("conflict_inst", if_inst, 32'hA0B0C0D0);
      @(posedge clk); #2; if_req = 1'b0;

      // Write holds we/wdata and leaves mem_rdata alone
      ack_delay = 3;
      @(posedge clk); #2; mem_wr_en = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hDEADBEEF;
      wait_for("write_grant", 0, c, nreq);
      check("write_we", ext_we, 1);
      check("write_wdata", ext_wdata, 32'hDEADBEEF);
      wait_for("write_done", 2, c, nreq);
      check("write_rdata_kept", mem_rdata, 32'h12345678);
      @(posedge clk); #2; mem_wr_en = 1'b0;

      // Read and write both high behaves as a write
      ack_delay = 1;
      @(posedge clk); #2; mem_rd_en = 1'b1; mem_wr_en = 1'b1; mem_addr = 32'h310;
      mem_wdata = 32'h0BADCAFE;
      wait_for("rw_grant", 0, c, nreq);
      check("rw_is_write", ext_we, 1);
      wait_for("rw_done", 2, c, nreq);
      @(posedge clk); #2; mem_rd_en = 1'b0; mem_wr_en = 1'b0;

      // Ack on the last allowed cycle is a good completion
      ack_delay = 4;
      @(posedge clk); #2; if_req = 1'b1; if_addr = 32'h104;
      wait_for("late_ack_done", 1, c, nreq);
      check("late_ack_busy", nreq, 4);
      check("late_ack_inst", if_inst, 32'hA0B0C0D0);
      check("late_ack_no_err", bus_err, 0);
      @(posedge clk); #2; if_req = 1'b0;

      // Hung fetch aborts after TIMEOUT busy cycles
      ack_delay = 0;
      @(posedge clk); #2; if_req = 1'b1; if_addr = 32'h600;
      wait_for("to_fetch_done", 1, c, nreq);
      check("to_fetch_busy", nreq, 4);
      check("to_fetch_inst", if_inst, NOP);
      check("to_fetch_err", bus_err, 1);
      @(posedge clk); #2; if_req = 1'b0;

      // Good read afterwards, error stays sticky
      ack_delay = 1;
      @(posedge clk); #2; mem_rd_en = 1'b1; mem_addr = 32'h200;
      wait_for("sticky_read_done", 2, c, nreq);
      check("sticky_rdata", mem_rdata, 32'h12345678);
      check("sticky_err", bus_err, 1);
      @(posedge clk); #2; mem_rd_en = 1'b0;

      // Hung data read returns zero
      ack_delay = 0;
      @(posedge clk); #2; mem_rd_en = 1'b1; mem_addr = 32'h700;
      wait_for("to_data_done", 2, c, nreq);
      check("to_data_rdata", mem_rdata, 0);
      check("to_data_err", bus_err, 1);
      @(posedge clk); #2; mem_rd_en = 1'b0;

      // Fairness with both sides requesting continuously
      do_reset();
      @(negedge clk);
      check("fair_err_cleared", bus_err, 0);
      ack_delay = 1;
      base = glog.size();
      @(posedge clk); #2;
      if_req = 1'b1; if_addr = 32'h400; mem_rd_en = 1'b1; mem_addr = 32'h500;
      c = 0;
      while (glog.size() < base + 6 && c < 200) begin
         @(negedge clk);
         c++;
      end
      wait_for("fair_last_done", 1, c, nreq);
      @(posedge clk); #2; if_req = 1'b0; mem_rd_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("fair_grant%0d", i), (glog.size() > base + i) ? glog[base + i] : 0,
               (i % 2 == 0) ? 2 : 1);
      end

      // Reset in the middle of a data access
      ack_delay = 0;
      @(posedge clk); #2; mem_rd_en = 1'b1; mem_addr = 32'h200;
      wait_for("rst_mid_grant", 0, c, nreq);
      @(posedge clk); #3; rst = 1'b0;
      #1;
      check("rst_mid_ext_req", ext_req, 0);
      check("rst_mid_mem_ready", mem_ready, 0);
      check("rst_mid_freeze", if_freeze, 1);
      mem_rd_en = 1'b0;
      stray_req++;
      @(posedge clk);
      @(posedge clk); #2; rst = 1'b1;
      stray_req++;
      repeat (3) @(negedge clk);
      check("rst_stray_ack_req", ext_req, 0);
      check("rst_stray_ack_ready", mem_ready, 0);
      ack_delay = 1;
      @(posedge clk); #2;
      if_req = 1'b1; if_addr = 32'h104; mem_rd_en = 1'b1; mem_addr = 32'h200;
      wait_for("rst_conflict_grant", 0, c, nreq);
      check("rst_conflict_first_addr", ext_addr, 32'h200);
      wait_for("rst_conflict_data_done", 2, c, nreq);
      @(posedge clk); #2; mem_rd_en = 1'b0;
      wait_for("rst_conflict_fetch_done", 1, c, nreq);
      @(posedge clk); #2; if_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
